coin_conditioner: RTL



---
 rtl/coin_conditioner.sv | 111 +++++++++++
 1 files changed

// File: rtl/coin_conditioner.sv
// Coin-slot front end: synchronizes and debounces two raw coin sensors, then
// arbitrates their rising events into single-cycle credit or reject pulses.
module coin_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int LOCKOUT     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_x,
    input  logic raw_y,
    input  logic en,
    output logic inx,
    output logic iny,
    output logic reject,
    output logic busy
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int LW = $clog2(LOCKOUT + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT);

    // Channel 0 is coin X, channel 1 is coin Y.
    logic [SYNC_STAGES-1:0] sync_r [2];
    logic [CW-1:0]          cnt_r  [2];
    logic [1:0]             raw_s;
    logic [1:0]             s_s;
    logic [1:0]             stable_r;
    logic [1:0]             stable_prev_r;
    logic [1:0]             ev_s;
    logic [LW-1:0]          lock_r;
    logic [LW-1:0]          lock_next_s;
    logic                   inx_next_s;
    logic                   iny_next_s;
    logic                   reject_next_s;

    assign raw_s = {raw_y, raw_x};
    assign s_s   = {sync_r[1][SYNC_STAGES-1], sync_r[0][SYNC_STAGES-1]};
    assign ev_s  = stable_r & ~stable_prev_r;
    assign busy  = (lock_r != '0);

    // Per-channel synchronizer chain and debounce of the synchronized level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                sync_r[c] <= '0;
                cnt_r[c]  <= '0;
            end
            stable_r      <= 2'b00;
            stable_prev_r <= 2'b00;
        end else begin
            stable_prev_r <= stable_r;
            for (int c = 0; c < 2; c++) begin
                sync_r[c] <= {sync_r[c][SYNC_STAGES-2:0], raw_s[c]};
                if (s_s[c] == stable_r[c]) begin
                    cnt_r[c] <= '0;
                end else if (cnt_r[c] == DB_LAST) begin
                    stable_r[c] <= ~stable_r[c];
                    cnt_r[c]    <= '0;
                end else begin
                    cnt_r[c] <= cnt_r[c] + CW'(1);
                end
            end
        end
    end

    // Arbitration: coincident coins or coins during lockout are rejected.
    always_comb begin
        inx_next_s    = 1'b0;
        iny_next_s    = 1'b0;
        reject_next_s = 1'b0;
        if (en && (ev_s != 2'b00)) begin
            if ((lock_r != '0) || (ev_s == 2'b11)) begin
                reject_next_s = 1'b1;
            end else if (ev_s[0]) begin
                inx_next_s = 1'b1;
            end else begin
                iny_next_s = 1'b1;
            end
        end else begin
            reject_next_s = 1'b0;
        end
    end

    // Lockout reloads on any outgoing pulse, otherwise counts down to zero.
    always_comb begin
        lock_next_s = lock_r;
        if (inx_next_s || iny_next_s || reject_next_s) begin
            lock_next_s = LOCK_LOAD;
        end else if (lock_r != '0) begin
            lock_next_s = lock_r - LW'(1);
        end else begin
            lock_next_s = '0;
        end
    end

    // Registered output pulses and lockout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            inx    <= 1'b0;
            iny    <= 1'b0;
            reject <= 1'b0;
            lock_r <= '0;
        end else begin
            inx    <= inx_next_s;
            iny    <= iny_next_s;
            reject <= reject_next_s;
            lock_r <= lock_next_s;
        end
    end
endmodule
